// File: rtl/ex_pkg.sv
// Shared types for the RV32 execute stage: ALU/branch/muldiv opcodes and muldiv FSM states.
package ex_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // Matches the RV32 branch funct3 field so decode can pass it straight through.
    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd4,
        BR_GE  = 3'd5,
        BR_LTU = 3'd6,
        BR_GEU = 3'd7
    } branch_cond_t;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    function automatic logic md_is_div(md_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative RV32M unit: 32-step radix-2 multiply / restoring divide on magnitudes, sign fixed in DONE.
// Only compiled when RV_MULDIV_EN is defined.
`ifdef RV_MULDIV_EN
// state   | meaning
// MD_IDLE | waiting for start; operands latched on start
// MD_BUSY | one shift-add / shift-subtract step per cycle, count 31..0
// MD_DONE | result valid for one cycle
module muldiv
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_t   state, state_nx;
    md_op_t      op_q;
    logic [4:0]  count;
    logic [31:0] hi, lo, mag_b_q, a_q;
    logic        neg_res, neg_rem, b_zero;

    logic        a_signed, b_signed, sa, sb;
    logic [32:0] add_sum, r_shift;
    logic [33:0] diff;
    logic        ge;
    logic [63:0] prod, prod_s;
    logic [31:0] quo, rem;

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);

    always_ff @(posedge clk) begin
        if (!reset) state <= MD_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            MD_IDLE: if (start) state_nx = MD_BUSY;
            MD_BUSY: if (count == 5'd0) state_nx = MD_DONE;
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
        if (abort) state_nx = MD_IDLE;
    end

    assign a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    assign b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    assign sa       = a_signed & a[31];
    assign sb       = b_signed & b[31];

    assign add_sum = {1'b0, hi} + {1'b0, (lo[0] ? mag_b_q : 32'd0)};
    assign r_shift = {hi, lo[31]};
    assign diff    = {1'b0, r_shift} - {2'b00, mag_b_q};
    assign ge      = ~diff[33];

    always_ff @(posedge clk) begin
        if (state == MD_IDLE && start) begin
            op_q    <= md_op_t'(op);
            a_q     <= a;
            hi      <= 32'd0;
            lo      <= sa ? -a : a;
            mag_b_q <= sb ? -b : b;
            neg_res <= sa ^ sb;
            neg_rem <= sa;
            b_zero  <= (b == 32'd0);
            count   <= 5'd31;
        end else if (state == MD_BUSY) begin
            if (md_is_div(op_q)) begin
                hi <= ge ? diff[31:0] : r_shift[31:0];
                lo <= {lo[30:0], ge};
            end else begin
                hi <= add_sum[32:1];
                lo <= {add_sum[0], lo[31:1]};
            end
            count <= count - 5'd1;
        end
    end

    assign prod   = {hi, lo};
    assign prod_s = neg_res ? -prod : prod;
    assign quo    = neg_res ? -lo : lo;
    assign rem    = neg_rem ? -hi : hi;

    // Divide by zero bypasses sign correction: all-ones quotient, original dividend as remainder.
    always_comb begin
        result = 32'd0;
        case (op_q)
            MD_MUL:                       result = prod[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_s[63:32];
            MD_DIV, MD_DIVU:              result = b_zero ? 32'hFFFF_FFFF : quo;
            MD_REM, MD_REMU:              result = b_zero ? a_q : rem;
            default:                      result = 32'd0;
        endcase
    end

endmodule
`endif

// File: rtl/ex_stage.sv
// RV32 execute stage: ALU, branch compare, optional iterative muldiv (RV_MULDIV_EN) and EX/MEM register.
// Without RV_MULDIV_EN, md_en instructions complete in one cycle with a zero result.
module ex_stage
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [XLEN-1:0] reg_out_b_in,
    input  logic [3:0]      alu_op,
    input  logic [2:0]      branch_cond,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    input  logic            flush,
    input  logic            mem_we_in,
    input  logic            mem_re_in,
    input  logic            branch_instruction_in,
    input  logic            reg_file_write_in,
    input  logic [4:0]      addr_rd_in,
    input  logic [1:0]      select_mux_4_in,
    input  logic [1:0]      select_mux_2_in,
    output logic            stall,
    output logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] reg_out_b,
    output logic            branch_out,
    output logic            mem_we,
    output logic            mem_re,
    output logic            branch_instruction,
    output logic            reg_file_write,
    output logic [4:0]      addr_rd_out,
    output logic [1:0]      select_mux_4_out,
    output logic [1:0]      select_mux_2_out
);

    logic [XLEN-1:0] alu_result, ex_result;
    logic [4:0]      shamt;
    logic            br_taken;

    assign shamt = operand_b[4:0];

    always_comb begin
        alu_result = 32'd0;
        case (alu_op_t'(alu_op))
            ALU_ADD:  alu_result = operand_a + operand_b;
            ALU_SUB:  alu_result = operand_a - operand_b;
            ALU_AND:  alu_result = operand_a & operand_b;
            ALU_OR:   alu_result = operand_a | operand_b;
            ALU_XOR:  alu_result = operand_a ^ operand_b;
            ALU_SLL:  alu_result = operand_a << shamt;
            ALU_SRL:  alu_result = operand_a >> shamt;
            ALU_SRA:  alu_result = $signed(operand_a) >>> shamt;
            ALU_SLT:  alu_result = {31'd0, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: alu_result = {31'd0, operand_a < operand_b};
            default:  alu_result = 32'd0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (branch_cond_t'(branch_cond))
            BR_EQ:   br_taken = (operand_a == operand_b);
            BR_NE:   br_taken = (operand_a != operand_b);
            BR_LT:   br_taken = ($signed(operand_a) <  $signed(operand_b));
            BR_GE:   br_taken = ($signed(operand_a) >= $signed(operand_b));
            BR_LTU:  br_taken = (operand_a <  operand_b);
            BR_GEU:  br_taken = (operand_a >= operand_b);
            default: br_taken = 1'b0;
        endcase
    end

`ifdef RV_MULDIV_EN
    logic            md_busy, md_done, md_start;
    logic [XLEN-1:0] md_result;

    // Start only from IDLE; DONE ignores md_en so the held instruction is not re-issued.
    assign md_start  = reset & ~flush & md_en & ~md_busy & ~md_done;
    assign stall     = md_start | (reset & ~flush & md_busy);
    assign ex_result = md_done ? md_result : alu_result;

    muldiv u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .abort  (flush),
        .op     (md_op),
        .a      (operand_a),
        .b      (operand_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );
`else
    logic unused_md_op;

    assign unused_md_op = ^md_op;
    assign stall        = 1'b0;
    assign ex_result    = md_en ? 32'd0 : alu_result;
`endif

    // Bubbles clear only the side-effecting controls; data fields hold their last value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_out            <= 32'd0;
            reg_out_b          <= 32'd0;
            branch_out         <= 1'b0;
            mem_we             <= 1'b0;
            mem_re             <= 1'b0;
            branch_instruction <= 1'b0;
            reg_file_write     <= 1'b0;
            addr_rd_out        <= 5'd0;
            select_mux_4_out   <= 2'd0;
            select_mux_2_out   <= 2'd0;
        end else if (flush || stall) begin
            mem_we             <= 1'b0;
            mem_re             <= 1'b0;
            branch_instruction <= 1'b0;
            reg_file_write     <= 1'b0;
        end else begin
            alu_out            <= ex_result;
            reg_out_b          <= reg_out_b_in;
            branch_out         <= br_taken;
            mem_we             <= mem_we_in;
            mem_re             <= mem_re_in;
            branch_instruction <= branch_instruction_in;
            reg_file_write     <= reg_file_write_in;
            addr_rd_out        <= addr_rd_in;
            select_mux_4_out   <= select_mux_4_in;
            select_mux_2_out   <= select_mux_2_in;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: random ALU/branch traffic and muldiv ops against arithmetic reference functions.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] operand_a, operand_b, reg_out_b_in;
    logic [3:0]  alu_op;
    logic [2:0]  branch_cond, md_op;
    logic        md_en, flush;
    logic        mem_we_in, mem_re_in, branch_instruction_in, reg_file_write_in;
    logic [4:0]  addr_rd_in;
    logic [1:0]  select_mux_4_in, select_mux_2_in;
    logic        stall;
    logic [31:0] alu_out, reg_out_b;
    logic        branch_out, mem_we, mem_re, branch_instruction, reg_file_write;
    logic [4:0]  addr_rd_out;
    logic [1:0]  select_mux_4_out, select_mux_2_out;

    int errors = 0;
    int checks = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .operand_a(operand_a), .operand_b(operand_b),
        .reg_out_b_in(reg_out_b_in), .alu_op(alu_op), .branch_cond(branch_cond),
        .md_en(md_en), .md_op(md_op), .flush(flush), .mem_we_in(mem_we_in),
        .mem_re_in(mem_re_in), .branch_instruction_in(branch_instruction_in),
        .reg_file_write_in(reg_file_write_in), .addr_rd_in(addr_rd_in),
        .select_mux_4_in(select_mux_4_in), .select_mux_2_in(select_mux_2_in),
        .stall(stall), .alu_out(alu_out), .reg_out_b(reg_out_b), .branch_out(branch_out),
        .mem_we(mem_we), .mem_re(mem_re), .branch_instruction(branch_instruction),
        .reg_file_write(reg_file_write), .addr_rd_out(addr_rd_out),
        .select_mux_4_out(select_mux_4_out), .select_mux_2_out(select_mux_2_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [44:0] ctrl_in();
        return {mem_we_in, mem_re_in, branch_instruction_in, reg_file_write_in,
                addr_rd_in, select_mux_4_in, select_mux_2_in, reg_out_b_in};
    endfunction

    function automatic logic [44:0] ctrl_out();
        return {mem_we, mem_re, branch_instruction, reg_file_write,
                addr_rd_out, select_mux_4_out, select_mux_2_out, reg_out_b};
    endfunction

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        int sh;
        logic [63:0] ext;
        sh  = int'(b[4:0]);
        ext = {{32{a[31]}}, a};
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: begin ext = ext >> sh; return ext[31:0]; end
            4'd8: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_branch(logic [2:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) <  int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p, ua64, ub64;
        sa = int'(a);
        sb = int'(b);
        ub = {32'd0, b};
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        case (op)
            3'd0: begin p = ua64 * ub64; return p[31:0]; end
            3'd1: begin p = sa * sb;     return p[63:32]; end
            3'd2: begin p = sa * ub;     return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return int'(a) / int'(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return int'(a) % int'(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic clear_inputs();
        operand_a = 0; operand_b = 0; reg_out_b_in = 0; alu_op = 0; branch_cond = 0;
        md_en = 0; md_op = 0; flush = 0; mem_we_in = 0; mem_re_in = 0;
        branch_instruction_in = 0; reg_file_write_in = 0; addr_rd_in = 0;
        select_mux_4_in = 0; select_mux_2_in = 0;
    endtask

    task automatic random_ctrl();
        mem_we_in = 1'($urandom); mem_re_in = 1'($urandom);
        branch_instruction_in = 1'($urandom); reg_file_write_in = 1'($urandom);
        addr_rd_in = 5'($urandom); select_mux_4_in = 2'($urandom);
        select_mux_2_in = 2'($urandom); reg_out_b_in = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        operand_a = 32'h1234; operand_b = 32'h55; reg_out_b_in = 32'hABCD; alu_op = 4'd0;
        branch_cond = 3'd1; md_en = 1'b1; md_op = 3'd0; flush = 1'b0;
        mem_we_in = 1; mem_re_in = 1; branch_instruction_in = 1; reg_file_write_in = 1;
        addr_rd_in = 5'd7; select_mux_4_in = 2'd3; select_mux_2_in = 2'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ctrl_out(), alu_out, branch_out} !== 78'd0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0", {ctrl_out(), alu_out, branch_out});
            end
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_stall: got %b expected 0", stall);
            end
        end
        reset = 1'b1;
        clear_inputs();
        operand_a = 32'd5; operand_b = 32'd7; alu_op = ALU_ADD;
        step();
        checks++;
        if (alu_out !== 32'd12) begin
            errors++;
            $display("FAIL reset_add: got %h expected %h", alu_out, 32'd12);
        end
    endtask

    task automatic test_alu_directed();
        clear_inputs();
        operand_a = 32'd3; operand_b = 32'd5; alu_op = ALU_SUB; branch_cond = BR_LT;
        reg_file_write_in = 1; mem_re_in = 1; branch_instruction_in = 1;
        addr_rd_in = 5'd9; select_mux_4_in = 2'd2; select_mux_2_in = 2'd1;
        reg_out_b_in = 32'hDEAD_BEEF;
        step();
        checks++;
        if (alu_out !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL sub_result: got %h expected %h", alu_out, 32'hFFFF_FFFE);
        end
        checks++;
        if (branch_out !== 1'b1) begin
            errors++;
            $display("FAIL sub_blt: got %b expected 1", branch_out);
        end
        checks++;
        if (ctrl_out() !== {1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 2'd2, 2'd1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL sub_ctrl: got %h expected %h", ctrl_out(),
                     {1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 2'd2, 2'd1, 32'hDEAD_BEEF});
        end
    endtask

    task automatic test_alu_random();
        logic [2:0] conds [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [31:0] exp_r;
        logic        exp_b;
        logic [44:0] exp_c;
        for (int i = 0; i < 150; i++) begin
            clear_inputs();
            random_ctrl();
            alu_op      = 4'($urandom_range(0, 9));
            branch_cond = conds[$urandom_range(0, 5)];
            operand_a   = $urandom;
            operand_b   = ($urandom_range(0, 3) == 0) ? operand_a : $urandom;
            exp_r = ref_alu(alu_op, operand_a, operand_b);
            exp_b = ref_branch(branch_cond, operand_a, operand_b);
            exp_c = ctrl_in();
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL alu_stall: got %b expected 0", stall);
            end
            step();
            checks++;
            if (alu_out !== exp_r) begin
                errors++;
                $display("FAIL alu_rand op=%0d a=%h b=%h: got %h expected %h",
                         alu_op, operand_a, operand_b, alu_out, exp_r);
            end
            checks++;
            if (branch_out !== exp_b) begin
                errors++;
                $display("FAIL branch_rand cond=%0d a=%h b=%h: got %b expected %b",
                         branch_cond, operand_a, operand_b, branch_out, exp_b);
            end
            checks++;
            if (ctrl_out() !== exp_c) begin
                errors++;
                $display("FAIL ctrl_rand: got %h expected %h", ctrl_out(), exp_c);
            end
        end
    endtask

    task automatic test_muldiv();
        logic [2:0]  d_op  [6] = '{3'd1, 3'd0, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] d_a   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] d_b   [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] d_exp [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd0};
        logic [31:0] exp_r;
        logic        exp_b;
        logic [44:0] exp_c;
        int n;
        for (int i = 0; i < 30; i++) begin
            clear_inputs();
            random_ctrl();
            md_en       = 1'b1;
            alu_op      = 4'($urandom_range(0, 9));
            branch_cond = 3'd0;
            if (i < 6) begin
                md_op = d_op[i]; operand_a = d_a[i]; operand_b = d_b[i]; exp_r = d_exp[i];
            end else begin
                md_op     = 3'($urandom_range(0, 7));
                operand_a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                case ($urandom_range(0, 7))
                    0:       operand_b = 32'd0;
                    1:       operand_b = 32'hFFFF_FFFF;
                    2:       operand_b = 32'($urandom_range(1, 20));
                    default: operand_b = $urandom;
                endcase
                exp_r = ref_md(md_op, operand_a, operand_b);
            end
            exp_b = ref_branch(branch_cond, operand_a, operand_b);
            exp_c = ctrl_in();
`ifdef RV_MULDIV_EN
            n = 0;
            while (stall === 1'b1 && n < 40) begin
                step();
                n++;
                checks++;
                if ({mem_we, mem_re, branch_instruction, reg_file_write} !== 4'd0) begin
                    errors++;
                    $display("FAIL md_bubble cycle %0d: got %b expected 0000", n,
                             {mem_we, mem_re, branch_instruction, reg_file_write});
                end
            end
            checks++;
            if (n !== 33) begin
                errors++;
                $display("FAIL md_stall_len op=%0d: got %0d expected 33", md_op, n);
            end
`else
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL md_nostall: got %b expected 0", stall);
            end
            exp_r = 32'd0;
`endif
            step();
            checks++;
            if (alu_out !== exp_r) begin
                errors++;
                $display("FAIL md_result op=%0d a=%h b=%h: got %h expected %h",
                         md_op, operand_a, operand_b, alu_out, exp_r);
            end
            checks++;
            if ({ctrl_out(), branch_out} !== {exp_c, exp_b}) begin
                errors++;
                $display("FAIL md_ctrl: got %h expected %h", {ctrl_out(), branch_out}, {exp_c, exp_b});
            end
        end
    endtask

    task automatic test_flush();
        int n;
        clear_inputs();
        operand_a = 32'd1; operand_b = 32'd2; alu_op = ALU_ADD;
        mem_we_in = 1; mem_re_in = 1; branch_instruction_in = 1; reg_file_write_in = 1;
        flush = 1'b1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_alu_stall: got %b expected 0", stall);
        end
        step();
        checks++;
        if ({mem_we, mem_re, branch_instruction, reg_file_write} !== 4'd0) begin
            errors++;
            $display("FAIL flush_alu_bubble: got %b expected 0000",
                     {mem_we, mem_re, branch_instruction, reg_file_write});
        end
        clear_inputs();
        md_en = 1'b1; md_op = MD_DIV; operand_a = 32'd1000; operand_b = 32'd3;
        reg_file_write_in = 1'b1;
        repeat (10) step();
        flush = 1'b1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_md_stall: got %b expected 0", stall);
        end
        step();
        flush = 1'b0;
        checks++;
        if (reg_file_write !== 1'b0) begin
            errors++;
            $display("FAIL flush_md_rfw: got %b expected 0", reg_file_write);
        end
        md_op = MD_DIVU; operand_a = 32'd100; operand_b = 32'd7;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
`ifdef RV_MULDIV_EN
        if (n !== 33) begin
            errors++;
            $display("FAIL divu_stall_len: got %0d expected 33", n);
        end
`else
        if (n !== 0) begin
            errors++;
            $display("FAIL divu_stall_len: got %0d expected 0", n);
        end
`endif
        step();
        checks++;
`ifdef RV_MULDIV_EN
        if ({alu_out, reg_file_write} !== {32'd14, 1'b1}) begin
            errors++;
            $display("FAIL divu_after_flush: got %h expected %h", {alu_out, reg_file_write}, {32'd14, 1'b1});
        end
`else
        if ({alu_out, reg_file_write} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL divu_after_flush: got %h expected %h", {alu_out, reg_file_write}, {32'd0, 1'b1});
        end
`endif
        md_op = MD_MUL; operand_a = 32'd9; operand_b = 32'd9;
        repeat (5) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        clear_inputs();
        operand_a = 32'd1; operand_b = 32'd1; alu_op = ALU_ADD; reg_file_write_in = 1'b1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_midbusy_stall: got %b expected 0", stall);
        end
        step();
        checks++;
        if ({alu_out, reg_file_write} !== {32'd2, 1'b1}) begin
            errors++;
            $display("FAIL reset_midbusy_add: got %h expected %h", {alu_out, reg_file_write}, {32'd2, 1'b1});
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_muldiv();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RV32 pipeline, directly upstream of the memory stage. Computes the ALU result and branch condition, runs an optional iterative RV32M multiply/divide unit, and registers results plus pass-through control into the EX/MEM pipeline register whose outputs drive the memory stage. Asserts `stall` upstream while a multi-cycle operation is in flight and inserts bubbles downstream.

## Interface
- No parameters; widths fixed: XLEN 32, register address 5.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `operand_a`, `operand_b` in 32: ALU/muldiv operands, already forwarded and muxed.
- `reg_out_b_in` in 32: rs2 value for stores.
- `alu_op` in 4: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU (`ex_pkg` encodings).
- `branch_cond` in 3: EQ, NE, LT, GE, LTU, GEU.
- `md_en` in 1: instruction is RV32M; `md_op` in 3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `flush` in 1: kill the instruction in EX (branch taken downstream).
- Control inputs: `mem_we_in`, `mem_re_in`, `branch_instruction_in`, `reg_file_write_in` (1 each); `addr_rd_in` 5; `select_mux_4_in`, `select_mux_2_in` 2 each.
- `stall` out 1: hold IF/ID/ID-EX contents this cycle.
- Registered outputs: `alu_out` 32, `reg_out_b` 32, `branch_out` 1, `mem_we`, `mem_re`, `branch_instruction`, `reg_file_write` (1 each), `addr_rd_out` 5, `select_mux_4_out`, `select_mux_2_out` 2 each.

## Operation
- Shifts use `operand_b[4:0]`; SLT/SLTU write 32'd1/32'd0; all arithmetic modulo 2^32.
- `branch_out` = `branch_cond` evaluated on `operand_a`/`operand_b`; registered.
- Muldiv FSM states: IDLE, BUSY, DONE.
  - IDLE: `md_en`=1 -> latch operands/op, magnitudes for signed ops, count=31, go BUSY.
  - BUSY: one radix-2 shift-add (mul) or restoring shift-subtract (div) step per cycle; at count=0 go DONE.
  - DONE: sign-correct result, EX/MEM captures it with the current (held) control inputs, go IDLE; `md_en` ignored this cycle.
- `stall` = (IDLE & `md_en`) | BUSY; combinational, 0 in DONE.
- While `stall`=1, EX/MEM loads a bubble: `mem_we`, `mem_re`, `branch_instruction`, `reg_file_write` = 0; data outputs hold.
- Divide by zero: quotient 32'hFFFF_FFFF, remainder = dividend. Signed overflow (0x8000_0000 / -1): quotient 0x8000_0000, remainder 0. Full latency still applies.
- `flush`=1: EX/MEM loads a bubble; FSM aborts to IDLE; `stall`=0 that cycle. Priority: reset > flush > muldiv > ALU.

## Timing
- Reset (`reset`=0 at edge): all registered outputs 0, FSM IDLE; `stall` = 0 during reset.
- ALU instructions: 1 cycle; result on EX/MEM outputs after the next edge.
- Muldiv: presented at cycle T; `stall` high T..T+32; DONE at T+33; result on outputs after edge ending T+33 (34 cycles total). Next instruction presented T+34; back-to-back muldiv restarts cleanly.
- Reset or flush mid-BUSY: next cycle IDLE, no partial result written.

## Configuration
- `RV_MULDIV_EN` defined: muldiv sub-module and FSM compiled in as above.
- Undefined: no FSM, `stall` tied 0, `md_en`=1 instructions complete in 1 cycle with `alu_out` = 0 and all control passed through unchanged.

## Structure
- `ex_pkg`: `alu_op_t`, `branch_cond_t`, `md_op_t`, `md_state_t` enums, XLEN constant.
- Sub-module `muldiv`: iterative unit with start/abort/done, operands in, 32-bit result out; `ex_stage` holds ALU, branch compare, stall logic, EX/MEM register.

## Test plan
- Reset held low 3 cycles with nonzero inputs -> all outputs 0, `stall`=0; release -> ADD 5+7 gives `alu_out`=12 one edge later.
- SUB 3-5 with BLT, `reg_file_write_in`=1 -> `alu_out`=0xFFFF_FFFE, `branch_out`=1, controls passed through.
- MUL 0xFFFF_FFFF×2 (MULH and MUL) -> 0xFFFF_FFFF / 0xFFFF_FFFE; `stall` high exactly 33 cycles, result at cycle 34, bubbles meanwhile.
- DIV 7/0 -> 0xFFFF_FFFF; REM 7/0 -> 7; DIV 0x8000_0000/-1 -> 0x8000_0000; REM -> 0.
- `flush` at BUSY cycle 10 -> `stall` 0 next cycle, FSM IDLE, no `reg_file_write`; following DIVU 100/7 -> 14.
- Build without `RV_MULDIV_EN`: MUL presented -> `stall` never asserts, `alu_out`=0 after one edge.
